// File: rtl/dualshock_responder.sv
// dualshock_responder: pad-side DualShock/PSX serial responder.
// Oversamples psCLK/psSEL/psTXD in the I_CLK domain.
module dualshock_responder #(
    parameter int ACK_DELAY = 75,
    parameter int ACK_WIDTH = 50
) (
    input  logic        I_CLK,
    input  logic        I_RSTn,
    input  logic        I_psCLK,
    input  logic        I_psSEL,
    input  logic        I_psTXD,
    output logic        O_psRXD,
    output logic        O_psACK,
    input  logic [15:0] I_BTN,
    input  logic [7:0]  I_RX,
    input  logic [7:0]  I_RY,
    input  logic [7:0]  I_LX,
    input  logic [7:0]  I_LY,
    input  logic        I_ANALOG,
    output logic        O_VIB_SMALL,
    output logic [7:0]  O_VIB_LARGE,
    output logic        O_ACTIVE
);

    localparam int AMAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int CW = (AMAX < 2) ? 1 : $clog2(AMAX + 1);
    localparam logic [CW-1:0] DLY_END = CW'(ACK_DELAY - 1);
    localparam logic [CW-1:0] WID_END = CW'(ACK_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_XFER,
        S_ACK_WAIT,
        S_ACK,
        S_DONE,
        S_ABORT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    clk_s_q, sel_s_q;
    logic [1:0]    txd_s_q;
    logic [2:0]    bit_q, bit_d;
    logic [3:0]    idx_q, idx_d;
    logic [7:0]    rxsh_q, rxsh_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   btn_q, btn_d;
    logic [7:0]    arx_q, arx_d, ary_q, ary_d;
    logic [7:0]    alx_q, alx_d, aly_q, aly_d;
    logic          analog_q, analog_d;
    logic [7:0]    vib0_q, vib0_d, vib1_q, vib1_d;
    logic          complete_q, complete_d;
    logic          rxd_q, rxd_d, ack_q, ack_d;
    logic          vsm_q, vsm_d;
    logic [7:0]    vlg_q, vlg_d;

    logic       clk_fall, clk_rise, sel_fall, sel_rise;
    logic       shifting;
    logic [7:0] rx_next, tx_byte;
    logic [3:0] last_idx;

    assign clk_fall = clk_s_q[2] & ~clk_s_q[1];
    assign clk_rise = ~clk_s_q[2] & clk_s_q[1];
    assign sel_fall = sel_s_q[2] & ~sel_s_q[1];
    assign sel_rise = ~sel_s_q[2] & sel_s_q[1];
    assign rx_next  = {txd_s_q[1], rxsh_q[7:1]};
    assign last_idx = analog_q ? 4'd8 : 4'd4;
    assign shifting = (state_q == S_XFER) || (state_q == S_ACK_WAIT) ||
                      (state_q == S_ACK);

    always_comb begin
        tx_byte = aly_q;
        unique case (idx_q)
            4'd0:    tx_byte = 8'hFF;
            4'd1:    tx_byte = analog_q ? 8'h73 : 8'h41;
            4'd2:    tx_byte = 8'h5A;
            4'd3:    tx_byte = btn_q[7:0];
            4'd4:    tx_byte = btn_q[15:8];
            4'd5:    tx_byte = arx_q;
            4'd6:    tx_byte = ary_q;
            4'd7:    tx_byte = alx_q;
            default: tx_byte = aly_q;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        idx_d      = idx_q;
        rxsh_d     = rxsh_q;
        cnt_d      = cnt_q;
        btn_d      = btn_q;
        arx_d      = arx_q;
        ary_d      = ary_q;
        alx_d      = alx_q;
        aly_d      = aly_q;
        analog_d   = analog_q;
        vib0_d     = vib0_q;
        vib1_d     = vib1_q;
        complete_d = complete_q;
        rxd_d      = rxd_q;
        ack_d      = ack_q;
        vsm_d      = vsm_q;
        vlg_d      = vlg_q;
        if (sel_rise) begin
            // SEL release wins over anything else happening this cycle
            state_d    = S_IDLE;
            rxd_d      = 1'b1;
            ack_d      = 1'b1;
            complete_d = 1'b0;
            if (complete_q) begin
                vsm_d = (vib0_q == 8'hFF);
                vlg_d = vib1_q;
            end
        end else begin
            if (shifting && clk_fall) begin
                rxd_d = tx_byte[bit_q];
            end
            if (shifting && clk_rise) begin
                rxsh_d = rx_next;
                bit_d  = bit_q + 3'd1;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (sel_fall) begin
                        btn_d    = I_BTN;
                        arx_d    = I_RX;
                        ary_d    = I_RY;
                        alx_d    = I_LX;
                        aly_d    = I_LY;
                        analog_d = I_ANALOG;
                        bit_d    = 3'd0;
                        idx_d    = 4'd0;
                        cnt_d    = '0;
                        state_d  = S_XFER;
                    end
                end
                S_XFER: begin
                    if (clk_rise && bit_q == 3'd7) begin
                        if ((idx_q == 4'd0 && rx_next != 8'h01) ||
                            (idx_q == 4'd1 && rx_next != 8'h42)) begin
                            state_d = S_ABORT;
                            rxd_d   = 1'b1;
                        end else begin
                            if (idx_q == 4'd3) vib0_d = rx_next;
                            if (idx_q == 4'd4) vib1_d = rx_next;
                            if (idx_q == last_idx) begin
                                complete_d = 1'b1;
                                state_d    = S_DONE;
                                rxd_d      = 1'b1;
                            end else begin
                                state_d = S_ACK_WAIT;
                                cnt_d   = '0;
                            end
                        end
                    end
                end
                S_ACK_WAIT: begin
                    if (cnt_q == DLY_END) begin
                        state_d = S_ACK;
                        ack_d   = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ACK: begin
                    if (cnt_q == WID_END) begin
                        state_d = S_XFER;
                        ack_d   = 1'b1;
                        cnt_d   = '0;
                        idx_d   = (idx_q == 4'd8) ? 4'd8 : idx_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_DONE:  rxd_d = 1'b1;
                S_ABORT: rxd_d = 1'b1;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK or negedge I_RSTn) begin
        if (!I_RSTn) begin
            clk_s_q    <= '1;
            sel_s_q    <= '1;
            txd_s_q    <= '1;
            state_q    <= S_IDLE;
            bit_q      <= '0;
            idx_q      <= '0;
            rxsh_q     <= '0;
            cnt_q      <= '0;
            btn_q      <= '1;
            arx_q      <= 8'h80;
            ary_q      <= 8'h80;
            alx_q      <= 8'h80;
            aly_q      <= 8'h80;
            analog_q   <= 1'b0;
            vib0_q     <= '0;
            vib1_q     <= '0;
            complete_q <= 1'b0;
            rxd_q      <= 1'b1;
            ack_q      <= 1'b1;
            vsm_q      <= 1'b0;
            vlg_q      <= '0;
        end else begin
            clk_s_q    <= {clk_s_q[1:0], I_psCLK};
            sel_s_q    <= {sel_s_q[1:0], I_psSEL};
            txd_s_q    <= {txd_s_q[0], I_psTXD};
            state_q    <= state_d;
            bit_q      <= bit_d;
            idx_q      <= idx_d;
            rxsh_q     <= rxsh_d;
            cnt_q      <= cnt_d;
            btn_q      <= btn_d;
            arx_q      <= arx_d;
            ary_q      <= ary_d;
            alx_q      <= alx_d;
            aly_q      <= aly_d;
            analog_q   <= analog_d;
            vib0_q     <= vib0_d;
            vib1_q     <= vib1_d;
            complete_q <= complete_d;
            rxd_q      <= rxd_d;
            ack_q      <= ack_d;
            vsm_q      <= vsm_d;
            vlg_q      <= vlg_d;
        end
    end

    assign O_psRXD     = rxd_q;
    assign O_psACK     = ack_q;
    assign O_VIB_SMALL = vsm_q;
    assign O_VIB_LARGE = vlg_q;
    assign O_ACTIVE    = (state_q != S_IDLE) && (state_q != S_ABORT);

endmodule

// File: doc/dualshock_responder.md
# dualshock_responder

Pad-side responder for the DualShock/PSX serial protocol. It answers the console-side `dualshock_controller` poller over psCLK/psSEL/psTXD/psRXD/psACK, presents a snapshot of button and analog-stick state, and captures the host's vibration bytes. It serves as a loopback bench partner for the poller and as an emulated pad driven from keyboard input. It runs entirely in the system pixel-clock domain and oversamples the serial lines.

## Interface

Parameters:
- `ACK_DELAY`, default 75: I_CLK cycles from byte completion to the ACK falling edge.
- `ACK_WIDTH`, default 50: I_CLK cycles that ACK is held low.

Ports:
- `I_CLK` in 1: system clock. Must be at least 8× the psCLK frequency.
- `I_RSTn` in 1: reset. Asynchronous, active-low.
- `I_psCLK` in 1: serial clock from the host. Idles high.
- `I_psSEL` in 1: attention/select from the host. Active-low.
- `I_psTXD` in 1: host command data, LSB first.
- `O_psRXD` out 1: pad response data, LSB first. Idles high.
- `O_psACK` out 1: acknowledge. Active-low pulse.
- `I_BTN` in 16: button state, active-low. Bits 7:0 are {L D R U St R3 L3 Se}; bits 15:8 are {□ X O △ R1 L1 R2 L2}.
- `I_RX`, `I_RY`, `I_LX`, `I_LY` in 8 each: analog axes. 0x80 is centre.
- `I_ANALOG` in 1: 1 selects analog mode (ID 0x73), 0 selects digital mode (ID 0x41).
- `O_VIB_SMALL` out 1: small motor enable.
- `O_VIB_LARGE` out 8: large motor strength.
- `O_ACTIVE` out 1: high while a transaction is accepted (state is not IDLE or ABORT).

## Operation

- **Input conditioning:** psCLK, psSEL and psTXD each pass through a 2-FF synchroniser. Edges are detected on the synchronised signals (fall/rise strobes).
- **Transaction start (SEL falling):**
  - Snapshot I_BTN, the four axes and I_ANALOG.
  - Clear the bit and byte counters.
  - Move IDLE→XFER.
- **Response bytes by index:**
  - 0: 0xFF
  - 1: ID (0x41 or 0x73)
  - 2: 0x5A
  - 3: BTN[7:0]
  - 4: BTN[15:8]
  - 5: RX
  - 6: RY
  - 7: LX
  - 8: LY
- **Last byte:** index 4 in digital mode, index 8 in analog mode.
- **Bit timing:**
  - On psCLK falling edge k (k = 0..7), O_psRXD ← tx_byte[k].
  - On psCLK rising edge, shift psTXD into rx_shift at the MSB (LSB first) and increment the bit counter.
  - The 8th rising edge completes the byte.
- **Byte checks at completion:**
  - Index 0: rx must be 0x01. Otherwise → ABORT.
  - Index 1: rx must be 0x42. Otherwise → ABORT. The rx byte at index 2 is ignored.
  - Indices 3 and 4: latch rx into vib_shadow[0] and vib_shadow[1].
- **ACK:** If the completed byte is not the last byte and was not aborted, go XFER→ACK_WAIT. After ACK_DELAY cycles go to ACK, where O_psACK=0 for ACK_WIDTH cycles. Then return to XFER with byte index +1.
- **ACK overlap:** psCLK edges arriving during ACK_WAIT or ACK are still processed for the next byte. ACK does not gate shifting.
- **Last byte done:** set a `complete` flag and go to DONE. DONE ignores further clocks and drives O_psRXD=1.
- **ABORT:**
  - O_psRXD=1, no ACK.
  - Ignore all clocks until SEL rises.
- **SEL rising, from any state:**
  - Return to IDLE and force O_psRXD=1 and O_psACK=1.
  - If `complete` is set, update O_VIB_SMALL ← (vib_shadow[0]==0xFF) and O_VIB_LARGE ← vib_shadow[1].
  - Clear `complete`.
- **Partial transactions:** a transaction cut off mid-byte or mid-ACK never updates the vibration outputs.

## Timing

- **Reset values:** O_psRXD=1, O_psACK=1, O_VIB_SMALL=0, O_VIB_LARGE=0x00, O_ACTIVE=0, state=IDLE, all counters 0.
- **Edge response latency:** O_psRXD updates 3 I_CLK cycles after the psCLK falling edge at the pin (2 synchroniser cycles plus 1 register).
- **ACK falling edge:** ACK_DELAY+3 cycles after the 8th psCLK rising edge at the pin. The low phase lasts exactly ACK_WIDTH cycles.
- **Counter widths:** the ACK counter is wide enough for max(ACK_DELAY, ACK_WIDTH). The byte index is 4 bits and saturates at 8.
- **Simultaneous events:** SEL rising in the same cycle as a byte completion takes priority. Go to IDLE, with no ACK and no vibration update unless `complete` was already set.
- **Vibration update:** vibration outputs change 1 cycle after the SEL-rise strobe.

## Test plan

- **Analog poll:** I_ANALOG=1, BTN=0xFFFE, axes RX/RY/LX/LY = 0x80/0x7F/0x00/0xFF. Host sends 01 42 00 FF 40 00 00 00 00.
  - Expect bytes FF 73 5A FE FF 80 7F 00 FF.
  - Expect 8 ACK pulses, each ACK_WIDTH cycles wide, and none after byte 8.
  - After SEL rise: O_VIB_SMALL=1, O_VIB_LARGE=0x40.
- **Digital poll:** I_ANALOG=0. Host sends 01 42 00 00 00.
  - Expect bytes FF 41 5A + 2 button bytes, and exactly 4 ACKs.
- **Bad address:** first host byte 0x81.
  - Expect no ACK, O_psRXD held high for the rest of SEL low, and vibration outputs unchanged.
- **Snapshot:** I_BTN changes mid-transaction.
  - Response still carries the value captured at SEL fall.
- **Early SEL rise:** SEL rises after byte 3 while in ACK_WAIT.
  - O_psACK stays high, state returns to IDLE, vibration outputs are not updated, and the next full poll succeeds.
- **Mid-transaction reset:** assert I_RSTn low during byte 5.
  - All outputs return to their reset values immediately, asynchronously.
